// File: rtl/ffo_pipe.sv
// ffo_pipe: pipelined find-first-one engine with valid/ready on both sides.
// A tree of 2:1 merge nodes resolves one level per clock; the result for an
// accepted input appears after P = $clog2(N) register stages.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake
//   in_b                  vector to search (bit N-1 is the MSB)
//   in_lsb                0: zero count above the highest set bit
//                         1: index of the lowest set bit
//   in_tag                sideband tag, carried unchanged
//   out_valid / out_ready output handshake
//   out_v                 vector had at least one set bit
//   out_p                 result position (0 when out_v = 0)
//   out_tag               tag belonging to this result
module ffo_pipe #(
   parameter  int unsigned N  = 32,
   parameter  int unsigned TW = 4,
   localparam int unsigned P  = $clog2(N)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_b,
   input  logic          in_lsb,
   input  logic [TW-1:0] in_tag,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_v,
   output logic [P-1:0]  out_p,
   output logic [TW-1:0] out_tag
);

   // Single global advance: the whole pipe moves or the whole pipe holds.
   logic         adv;
   logic [N-1:0] b_norm;

   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;

   // LSB mode is folded in here: the zero count of the bit-reversed vector is
   // the index of the lowest set bit, so the tree only ever searches from the
   // MSB and the mode need not travel down the pipe.
   always_comb begin
      b_norm = in_b;
      if (in_lsb) begin
         for (int unsigned i = 0; i < N; i++) begin
            b_norm[i] = in_b[N-1-i];
         end
      end
   end

   // Stage k holds N>>k nodes, each with a valid bit and a k-bit position.
   // Node j of a stage is the j-th slice from the left (most significant).
   for (genvar k = 1; k <= P; k++) begin : g_stg
      localparam int unsigned NN = N >> k;

      logic [NN-1:0]   v_q, v_d;
      logic [NN*k-1:0] p_q, p_d;
      logic            valid_q, valid_d;
      logic [TW-1:0]   tag_q, tag_d;

      if (k == 1) begin : g_leaf
         always_comb begin
            valid_d = in_valid & adv;
            tag_d   = in_tag;
            v_d     = '0;
            p_d     = '0;
            for (int unsigned j = 0; j < NN; j++) begin
               v_d[j] = b_norm[N-1-2*j] | b_norm[N-2-2*j];
               p_d[j] = ~b_norm[N-1-2*j];
            end
         end
      end else begin : g_merge
         always_comb begin
            valid_d = g_stg[k-1].valid_q;
            tag_d   = g_stg[k-1].tag_q;
            v_d     = '0;
            p_d     = '0;
            for (int unsigned j = 0; j < NN; j++) begin
               v_d[j] = g_stg[k-1].v_q[2*j] | g_stg[k-1].v_q[2*j+1];
               p_d[j*k +: k] = g_stg[k-1].v_q[2*j]
                             ? {1'b0, g_stg[k-1].p_q[(2*j)*(k-1)   +: k-1]}
                             : {1'b1, g_stg[k-1].p_q[(2*j+1)*(k-1) +: k-1]};
            end
         end
      end

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            v_q     <= '0;
            p_q     <= '0;
         end else if (adv) begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            v_q     <= v_d;
            p_q     <= p_d;
         end
      end
   end

   // An all-zero vector leaves all ones in the tree position; force it to 0.
   assign out_valid = g_stg[P].valid_q;
   assign out_v     = out_valid & g_stg[P].v_q[0];
   assign out_p     = out_v ? g_stg[P].p_q : '0;
   assign out_tag   = out_valid ? g_stg[P].tag_q : '0;

endmodule

// File: tb/tb_ffo_pipe.sv
`timescale 1ns/1ps
module tb_ffo_pipe;

   typedef struct {
      logic        v;
      logic [7:0]  p;
      logic [3:0]  tag;
      int unsigned cyc;
      bit          lat;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic rdy   = 1'b1;

   // N = 32 instance
   logic        val0 = 1'b0, lsb0 = 1'b0;
   logic [31:0] b0   = '0;
   logic [3:0]  tag0 = '0;
   logic        ir0, ov0, v0;
   logic [4:0]  p0;
   logic [3:0]  t0;
   logic        xv = 1'b0;
   logic [7:0]  xp = '0;

   // N = 4 instance
   logic        val1 = 1'b0, lsb1 = 1'b0;
   logic [3:0]  b1   = '0;
   logic [3:0]  tag1 = '0;
   logic        ir1, ov1, v1;
   logic [1:0]  p1;
   logic [3:0]  t1;

   // N = 256 instance
   logic         val2 = 1'b0, lsb2 = 1'b0;
   logic [255:0] b2   = '0;
   logic [3:0]   tag2 = '0;
   logic         ir2, ov2, v2;
   logic [7:0]   p2;
   logic [3:0]   t2;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned tmo    = 0;
   int unsigned cyc    = 0;
   logic        lat_on = 1'b0;
   logic        bp_on  = 1'b0;
   logic        final_chk = 1'b0;
   logic [15:0] pat  = 16'b1011_0010_0110_1001;
   int unsigned pidx = 0;

   exp_t        q [3][$];
   bit          stall_q [3];
   logic [13:0] hold_q [3];
   logic [8:0]  r;

   ffo_pipe #(.N(32), .TW(4)) u_n32 (
      .clock(clock), .reset(reset),
      .in_valid(val0), .in_ready(ir0), .in_b(b0), .in_lsb(lsb0), .in_tag(tag0),
      .out_valid(ov0), .out_ready(rdy), .out_v(v0), .out_p(p0), .out_tag(t0)
   );

   ffo_pipe #(.N(4), .TW(4)) u_n4 (
      .clock(clock), .reset(reset),
      .in_valid(val1), .in_ready(ir1), .in_b(b1), .in_lsb(lsb1), .in_tag(tag1),
      .out_valid(ov1), .out_ready(rdy), .out_v(v1), .out_p(p1), .out_tag(t1)
   );

   ffo_pipe #(.N(256), .TW(4)) u_n256 (
      .clock(clock), .reset(reset),
      .in_valid(val2), .in_ready(ir2), .in_b(b2), .in_lsb(lsb2), .in_tag(tag2),
      .out_valid(ov2), .out_ready(rdy), .out_v(v2), .out_p(p2), .out_tag(t2)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Behavioural reference: {valid, position}
   function automatic logic [8:0] ref_ffo(input logic [255:0] b, input int unsigned n,
                                          input logic l);
      ref_ffo = '0;
      if (l) begin
         for (int unsigned i = n; i > 0; i--)
            if (b[i-1]) ref_ffo = {1'b1, 8'(i-1)};
      end else begin
         for (int unsigned i = 0; i < n; i++)
            if (b[i]) ref_ffo = {1'b1, 8'(n-1-i)};
      end
   endfunction

   task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", nm, obs, exp);
      end
   endtask

   task automatic mon(input int unsigned i, input string nm, input logic ov, input logic ir,
                      input logic v, input logic [7:0] p, input logic [3:0] t,
                      input int unsigned lat);
      exp_t        e;
      logic [13:0] now;
      now = {ov, v, p, t};
      if (stall_q[i]) chk({nm, "_hold"}, 32'(now), 32'(hold_q[i]));
      if (ov && !rdy) chk({nm, "_stall_ready"}, 32'(ir), 32'd0);
      if (!ov) chk({nm, "_idle"}, 32'({v, p, t, ir}), 32'd1);
      if (ov && rdy) begin
         chk({nm, "_expected"}, 32'(q[i].size() != 0), 32'd1);
         if (q[i].size() != 0) begin
            e = q[i].pop_front();
            chk({nm, "_v"}, 32'(v), 32'(e.v));
            chk({nm, "_p"}, 32'(p), 32'(e.p));
            chk({nm, "_tag"}, 32'(t), 32'(e.tag));
            if (e.lat) chk({nm, "_latency"}, cyc - e.cyc, lat);
         end
      end
      stall_q[i] = ov && !rdy;
      hold_q[i]  = now;
   endtask

   // Output monitor and scoreboard, sampled on the falling edge.
   initial forever begin
      @(negedge clock);
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            q[i].delete();
            stall_q[i] = 1'b0;
         end
         chk("rst_n32",  32'({ov0, v0, p0, t0, ir0}), 32'd1);
         chk("rst_n4",   32'({ov1, v1, p1, t1, ir1}), 32'd1);
         chk("rst_n256", 32'({ov2, v2, p2, t2, ir2}), 32'd1);
      end else begin
         mon(0, "n32",  ov0, ir0, v0, 8'(p0), t0, 5);
         mon(1, "n4",   ov1, ir1, v1, 8'(p1), t1, 2);
         mon(2, "n256", ov2, ir2, v2, p2,     t2, 8);
         if (val0 && ir0) q[0].push_back('{xv, xp, tag0, cyc, lat_on});
         if (val1 && ir1) begin
            r = ref_ffo(256'(b1), 4, lsb1);
            q[1].push_back('{r[8], r[7:0], tag1, cyc, lat_on});
         end
         if (val2 && ir2) begin
            r = ref_ffo(b2, 256, lsb2);
            q[2].push_back('{r[8], r[7:0], tag2, cyc, lat_on});
         end
      end
      if (final_chk) begin
         chk("drain_n32",  32'(q[0].size()), 32'd0);
         chk("drain_n4",   32'(q[1].size()), 32'd0);
         chk("drain_n256", 32'(q[2].size()), 32'd0);
         chk("timeouts",   tmo, 32'd0);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
      if (bp_on) begin
         rdy  = pat[pidx];
         pidx = (pidx + 1) % 16;
      end
   endtask

   task automatic put(input int unsigned d, input logic [255:0] b, input logic l,
                      input logic [3:0] t, input logic ev, input logic [7:0] ep);
      bit          acc = 1'b0;
      int unsigned n   = 0;
      if (d == 0) begin
         val0 = 1'b1; b0 = b[31:0]; lsb0 = l; tag0 = t; xv = ev; xp = ep;
      end else if (d == 1) begin
         val1 = 1'b1; b1 = b[3:0]; lsb1 = l; tag1 = t;
      end else begin
         val2 = 1'b1; b2 = b; lsb2 = l; tag2 = t;
      end
      while (!acc && n < 64) begin
         @(negedge clock);
         acc = (d == 0) ? ir0 : (d == 1) ? ir1 : ir2;
         tick();
         n++;
      end
      if (!acc) tmo++;
      val0 = 1'b0;
      val1 = 1'b0;
      val2 = 1'b0;
   endtask

   task automatic drain();
      int unsigned n = 0;
      while ((q[0].size() != 0 || q[1].size() != 0 || q[2].size() != 0) && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) tmo++;
   endtask

   int bits [7] = '{0, 1, 7, 100, 128, 254, 255};

   initial begin
      repeat (2) tick();
      reset = 1'b0;

      // MSB walking one, then zero
      lat_on = 1'b1;
      for (int i = 0; i < 32; i++)
         put(0, 256'(32'h1 << (31 - i)), 1'b0, 4'(i), 1'b1, 8'(i));
      put(0, 256'(32'h0), 1'b0, 4'd0, 1'b0, 8'd0);

      // LSB mode interleaved with MSB mode
      put(0, 256'(32'h0000_0100), 1'b1, 4'd1, 1'b1, 8'd8);
      put(0, 256'(32'h0001_0000), 1'b0, 4'd2, 1'b1, 8'd15);
      put(0, 256'(32'h8000_0001), 1'b1, 4'd3, 1'b1, 8'd0);
      put(0, 256'(32'h8000_0001), 1'b0, 4'd4, 1'b1, 8'd0);
      put(0, 256'(32'h8000_0000), 1'b1, 4'd5, 1'b1, 8'd31);
      put(0, 256'(32'h0000_0003), 1'b0, 4'd6, 1'b1, 8'd30);
      put(0, 256'(32'h0000_0003), 1'b1, 4'd7, 1'b1, 8'd0);
      drain();

      // Backpressure with a fixed out_ready pattern
      lat_on = 1'b0;
      bp_on  = 1'b1;
      for (int k = 0; k < 10; k++) begin
         int j;
         j = 3 * k + 1;
         put(0, 256'((32'h1 << j) | (32'h1 << (j / 2))), 1'(k % 2), 4'(k + 3), 1'b1,
             (k % 2 == 1) ? 8'(j / 2) : 8'(31 - j));
      end
      drain();
      bp_on = 1'b0;
      rdy   = 1'b1;

      // Reset during a stall: five in flight, all discarded
      rdy = 1'b0;
      for (int k = 0; k < 5; k++)
         put(0, 256'(32'h00F0_0000 >> k), 1'b0, 4'(k), 1'b1, 8'(8 + k));
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rdy    = 1'b1;
      lat_on = 1'b1;
      put(0, 256'(32'h0001_0000), 1'b0, 4'd9, 1'b1, 8'd15);
      drain();
      repeat (8) tick();

      // Back-to-back zeros and all-ones in both modes
      put(0, 256'(32'h0),         1'b0, 4'd10, 1'b0, 8'd0);
      put(0, 256'(32'h0),         1'b1, 4'd11, 1'b0, 8'd0);
      put(0, 256'(32'hFFFF_FFFF), 1'b0, 4'd12, 1'b1, 8'd0);
      put(0, 256'(32'hFFFF_FFFF), 1'b1, 4'd13, 1'b1, 8'd0);
      drain();

      // N = 4 exhaustive, both modes
      for (int l = 0; l < 2; l++)
         for (int b = 0; b < 16; b++)
            put(1, 256'(b), 1'(l), 4'(b), 1'b0, 8'd0);
      drain();

      // N = 256 random and single-bit vectors
      for (int k = 0; k < 8; k++)
         put(2, {8{$urandom()}}, 1'(k % 2), 4'(k), 1'b0, 8'd0);
      for (int l = 0; l < 2; l++)
         for (int s = 0; s < 7; s++)
            put(2, 256'(1) << bits[s], 1'(l), 4'(s), 1'b0, 8'd0);
      drain();

      repeat (4) tick();
      final_chk = 1'b1;
      tick();
      final_chk = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
